hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 9 +
 rtl/hazard_ld_entry.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared MIPS defines: register-index width and load-table defaults.
package hazard_scoreboard_pkg;

    localparam int MIPS_RF_REG_W = 5;
    localparam int MIPS_LD_DEPTH = 4;
    localparam int MIPS_LOAD_LAT = 1;
    localparam int LD_CNT_W      = 3;

endpackage

// File: rtl/hazard_ld_entry.sv
// rtl/hazard_ld_entry.sv - one outstanding-load entry: allocate, count down to retirement, match ID sources.
module hazard_ld_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int RF_REG_W = MIPS_RF_REG_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                set,
    input  logic [RF_REG_W-1:0] setDst,
    input  logic [LD_CNT_W-1:0] setCnt,
    input  logic [RF_REG_W-1:0] rs,
    input  logic                rsVld,
    input  logic [RF_REG_W-1:0] rt,
    input  logic                rtVld,
    output logic                valid,
    output logic                match
);

    logic [RF_REG_W-1:0] dst;
    logic [LD_CNT_W-1:0] cnt;

    // A valid entry ignores set, so an entry retiring this cycle cannot be reallocated until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            dst   <= '0;
            cnt   <= '0;
        end else if (valid) begin
            if (cnt <= LD_CNT_W'(1)) begin
                valid <= 1'b0;
                cnt   <= '0;
            end else begin
                cnt <= cnt - LD_CNT_W'(1);
            end
        end else if (set) begin
            valid <= 1'b1;
            dst   <= setDst;
            cnt   <= setCnt;
        end
    end

    // r0 is hardwired zero, so it never carries a dependency.
    assign match = valid & ((rsVld & (|rs) & (rs == dst)) | (rtVld & (|rt) & (rt == dst)));

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard scoreboard with stall/flush control; HAZARD_STATS_EN adds a stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RF_REG_W = MIPS_RF_REG_W,
    parameter int LD_DEPTH = MIPS_LD_DEPTH,
    parameter int LOAD_LAT = MIPS_LOAD_LAT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [RF_REG_W-1:0] iID_Rs,
    input  logic [RF_REG_W-1:0] iID_Rt,
    input  logic                iID_RsVld,
    input  logic                iID_RtVld,
    input  logic                iID_Vld,
    input  logic                iID_IsLoad,
    input  logic [RF_REG_W-1:0] iID_Dst,
    input  logic                iBranchTaken,
    output logic                oPCWr,
    output logic                oIFDWr,
    output logic                oBubble,
    output logic                oFlush,
    output logic                oBusy,
    output logic [31:0]         oStallCycles
);

    logic [LD_DEPTH-1:0] validVec;
    logic [LD_DEPTH-1:0] matchVec;
    logic [LD_DEPTH-1:0] setVec;
    logic                fullStall;
    logic                stall;
    logic                issue;
    logic                found;

    for (genvar g = 0; g < LD_DEPTH; g++) begin : gEntry
        hazard_ld_entry #(
            .RF_REG_W(RF_REG_W)
        ) uEntry (
            .clk    (clk),
            .resetn (resetn),
            .set    (setVec[g]),
            .setDst (iID_Dst),
            .setCnt (LD_CNT_W'(LOAD_LAT)),
            .rs     (iID_Rs),
            .rsVld  (iID_RsVld),
            .rt     (iID_Rt),
            .rtVld  (iID_RtVld),
            .valid  (validVec[g]),
            .match  (matchVec[g])
        );
    end

    assign fullStall = iID_Vld & iID_IsLoad & (&validVec);
    assign stall     = iID_Vld & ((|matchVec) | fullStall) & ~iBranchTaken;
    assign issue     = iID_Vld & iID_IsLoad & ~stall & ~iBranchTaken & (|iID_Dst);

    // Lowest-index free entry takes the new load.
    always_comb begin
        setVec = '0;
        found  = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (!validVec[i] && !found) begin
                setVec[i] = issue;
                found     = 1'b1;
            end
        end
    end

    assign oPCWr   = ~stall;
    assign oIFDWr  = ~stall;
    assign oBubble = stall | iBranchTaken;
    assign oFlush  = iBranchTaken;
    assign oBusy   = |validVec;

`ifdef HAZARD_STATS_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign oStallCycles = stallCnt;
`else
    assign oStallCycles = 32'd0;
`endif

endmodule
